// File: rtl/step_idle_monitor.sv
// Stepper idle watchdog: per-channel idle timers, filtered endstop arming and a
// sticky shutdown request feeding the command block, plus LED debug taps.
module step_idle_monitor #(
  parameter int          NCH        = 6,
  parameter int unsigned TIMEOUT    = 480000000,
  parameter int unsigned WATCH_MASK = 6'b100000,
  parameter int unsigned ARM_FILTER = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] step,
  input  logic           arm_endstop,
  input  logic           shutdown_clr,
  output logic           req_shutdown,
  output logic [NCH-1:0] alert,
  output logic           armed,
  output logic [7:0]     idle_dbg
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(ARM_FILTER + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);
  localparam logic [FW-1:0]  FILT_MAX = FW'(ARM_FILTER);
  localparam logic [NCH-1:0] WMASK    = NCH'(WATCH_MASK);

  if (NCH < 1) begin : g_err_nch
    $error("step_idle_monitor: NCH must be at least 1");
  end
  if ((WATCH_MASK >> NCH) != 0) begin : g_err_mask
    $error("step_idle_monitor: WATCH_MASK has bits above NCH");
  end

  logic [NCH-1:0] prev_step_q;
  logic           es_meta_q, es_sync_q;
  logic [FW-1:0]  filt_q, filt_d;
  logic           armed_q, armed_d;
  logic           req_q, req_d;
  logic [NCH-1:0] alert_q, alert_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [7:0]     dbg_q, dbg_d;
  logic [NCH-1:0] step_edge;
  logic           trigger;

  // Both step polarities count as activity; shutdown_clr beats every other update.
  always_comb begin
    step_edge = step ^ prev_step_q;
    trigger   = armed_q & (|(alert_q & WMASK));
    cnt_d     = cnt_q;
    alert_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (shutdown_clr || step_edge[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
      alert_d[i] = !shutdown_clr && (cnt_q[i] == CNT_MAX);
    end

    filt_d = filt_q;
    if (shutdown_clr || es_sync_q) begin
      filt_d = '0;
    end else if (filt_q < FILT_MAX) begin
      filt_d = filt_q + FW'(1);
    end
    armed_d = !shutdown_clr && (armed_q || (filt_q == FILT_MAX));
    req_d   = !shutdown_clr && (req_q || trigger);
  end

  // Debug tap takes the top byte of the last channel's timer, zero-padded when narrow.
  if (CW >= 8) begin : g_dbg_wide
    assign dbg_d = cnt_q[NCH-1][CW-1 -: 8];
  end else begin : g_dbg_narrow
    assign dbg_d = {{(8 - CW){1'b0}}, cnt_q[NCH-1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_step_q <= '0;
      es_meta_q   <= 1'b1;
      es_sync_q   <= 1'b1;
      filt_q      <= '0;
      armed_q     <= 1'b0;
      req_q       <= 1'b0;
      alert_q     <= '0;
      dbg_q       <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      prev_step_q <= step;
      es_meta_q   <= arm_endstop;
      es_sync_q   <= es_meta_q;
      filt_q      <= filt_d;
      armed_q     <= armed_d;
      req_q       <= req_d;
      alert_q     <= alert_d;
      dbg_q       <= dbg_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_shutdown = req_q;
  assign alert        = alert_q;
  assign armed        = armed_q;
  assign idle_dbg     = dbg_q;

endmodule

// File: tb/tb_step_idle_monitor.sv
// Bench for step_idle_monitor: vector table for reset/arming, hand sequences for
// timeout, masking, clear race and mid-run reset, checked through a scoreboard queue.
module tb_step_idle_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] step;
  logic       arm_endstop;
  logic       shutdown_clr;
  logic       req_shutdown;
  logic [5:0] alert;
  logic       armed;
  logic [7:0] idle_dbg;

  int checks   = 0;
  int failures = 0;

  step_idle_monitor #(
    .NCH        (6),
    .TIMEOUT    (100),
    .WATCH_MASK (6'b100000),
    .ARM_FILTER (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .step         (step),
    .arm_endstop  (arm_endstop),
    .shutdown_clr (shutdown_clr),
    .req_shutdown (req_shutdown),
    .alert        (alert),
    .armed        (armed),
    .idle_dbg     (idle_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [5:0] step;
    logic       es;
    logic       clr;
    int         ncyc;
    logic       req;
    logic [5:0] alert;
    logic       armed;
    logic [7:0] dbg;
    bit         chk_dbg;
  } vec_t;

  typedef struct {
    string      name;
    logic       req;
    logic [5:0] alert;
    logic       armed;
    logic [7:0] dbg;
    bit         chk_dbg;
  } exp_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  exp_t sb_q [$];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string nm, input logic rq, input logic [5:0] al,
                          input logic ar, input logic [7:0] dg, input bit cd);
    exp_t e;
    e.name = nm; e.req = rq; e.alert = al; e.armed = ar; e.dbg = dg; e.chk_dbg = cd;
    sb_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL sb_empty: no expectation queued at t=%0t", $time);
      return;
    end
    e = sb_q.pop_front();
    if (req_shutdown !== e.req) begin
      failures++;
      $display("FAIL %s.req_shutdown got=%0b exp=%0b", e.name, req_shutdown, e.req);
    end
    checks++;
    if (alert !== e.alert) begin
      failures++;
      $display("FAIL %s.alert got=%h exp=%h", e.name, alert, e.alert);
    end
    checks++;
    if (armed !== e.armed) begin
      failures++;
      $display("FAIL %s.armed got=%0b exp=%0b", e.name, armed, e.armed);
    end
    if (e.chk_dbg) begin
      checks++;
      if (idle_dbg !== e.dbg) begin
        failures++;
        $display("FAIL %s.idle_dbg got=%0d exp=%0d", e.name, idle_dbg, e.dbg);
      end
    end
  endtask

  task automatic expect_now(input string nm, input logic rq, input logic [5:0] al,
                            input logic ar, input logic [7:0] dg, input bit cd);
    push_exp(nm, rq, al, ar, dg, cd);
    check_pop();
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0; step = '0; arm_endstop = 1'b1; shutdown_clr = 1'b0;
    cyc(2);
    expect_now(nm, 1'b0, 6'h00, 1'b0, 8'd0, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; step = '0; arm_endstop = 1'b1; shutdown_clr = 1'b0;

    // rst_n, step, es, clr, ncyc, req, alert, armed, dbg, chk_dbg
    vecs[0]  = '{1'b0, 6'h15, 1'b1, 1'b0, 1,   1'b0, 6'h00, 1'b0, 8'd0,   1'b1};
    vecs[1]  = '{1'b0, 6'h2A, 1'b1, 1'b0, 1,   1'b0, 6'h00, 1'b0, 8'd0,   1'b1};
    vecs[2]  = '{1'b0, 6'h15, 1'b1, 1'b0, 1,   1'b0, 6'h00, 1'b0, 8'd0,   1'b1};
    vecs[3]  = '{1'b0, 6'h2A, 1'b1, 1'b0, 1,   1'b0, 6'h00, 1'b0, 8'd0,   1'b1};
    vecs[4]  = '{1'b0, 6'h15, 1'b1, 1'b0, 1,   1'b0, 6'h00, 1'b0, 8'd0,   1'b1};
    vecs[5]  = '{1'b1, 6'h00, 1'b1, 1'b0, 100, 1'b0, 6'h00, 1'b0, 8'd99,  1'b1};
    vecs[6]  = '{1'b1, 6'h00, 1'b1, 1'b0, 1,   1'b0, 6'h3F, 1'b0, 8'd100, 1'b1};
    vecs[7]  = '{1'b1, 6'h00, 1'b1, 1'b0, 5,   1'b0, 6'h3F, 1'b0, 8'd100, 1'b1};
    vecs[8]  = '{1'b0, 6'h00, 1'b1, 1'b0, 2,   1'b0, 6'h00, 1'b0, 8'd0,   1'b1};
    vecs[9]  = '{1'b1, 6'h00, 1'b0, 1'b0, 3,   1'b0, 6'h00, 1'b0, 8'd2,   1'b1};
    vecs[10] = '{1'b1, 6'h00, 1'b1, 1'b0, 8,   1'b0, 6'h00, 1'b0, 8'd10,  1'b1};
    vecs[11] = '{1'b1, 6'h00, 1'b0, 1'b0, 6,   1'b0, 6'h00, 1'b0, 8'd16,  1'b1};
    vecs[12] = '{1'b1, 6'h00, 1'b0, 1'b0, 1,   1'b0, 6'h00, 1'b1, 8'd17,  1'b1};
    vecs[13] = '{1'b1, 6'h00, 1'b1, 1'b0, 10,  1'b0, 6'h00, 1'b1, 8'd27,  1'b1};

    for (int i = 0; i < NV; i++) begin
      rst_n        = vecs[i].rst_n;
      step         = vecs[i].step;
      arm_endstop  = vecs[i].es;
      shutdown_clr = vecs[i].clr;
      push_exp($sformatf("vec%0d", i), vecs[i].req, vecs[i].alert, vecs[i].armed,
               vecs[i].dbg, vecs[i].chk_dbg);
      cyc(vecs[i].ncyc);
      check_pop();
    end

    // Watched channel kept alive, then abandoned.
    do_reset("t3_reset");
    arm_endstop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(50);
      step[5] = ~step[5];
    end
    expect_now("t3_toggling", 1'b0, 6'h1F, 1'b1, 8'd0, 1'b0);
    cyc(101);
    expect_now("t3_pre_alert", 1'b0, 6'h1F, 1'b1, 8'd0, 1'b0);
    cyc(1);
    expect_now("t3_alert", 1'b0, 6'h3F, 1'b1, 8'd0, 1'b0);
    cyc(1);
    expect_now("t3_req", 1'b1, 6'h3F, 1'b1, 8'd0, 1'b0);
    cyc(20);
    expect_now("t3_req_sticky", 1'b1, 6'h3F, 1'b1, 8'd0, 1'b0);

    // Unwatched channels idle while the watched one stays busy.
    do_reset("t4_reset");
    arm_endstop = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(20);
      step[5] = ~step[5];
    end
    expect_now("t4_mask", 1'b0, 6'h1F, 1'b1, 8'd0, 1'b0);

    // Clear pulse while the trigger is still live.
    do_reset("t5_reset");
    arm_endstop = 1'b0;
    cyc(110);
    expect_now("t5_tripped", 1'b1, 6'h3F, 1'b1, 8'd0, 1'b0);
    shutdown_clr = 1'b1;
    cyc(1);
    shutdown_clr = 1'b0;
    expect_now("t5_cleared", 1'b0, 6'h00, 1'b0, 8'd0, 1'b0);
    cyc(1);
    expect_now("t5_cnt_zero", 1'b0, 6'h00, 1'b0, 8'd0, 1'b1);
    cyc(3);
    expect_now("t5_not_rearmed", 1'b0, 6'h00, 1'b0, 8'd0, 1'b0);
    cyc(1);
    expect_now("t5_rearmed", 1'b0, 6'h00, 1'b1, 8'd0, 1'b0);
    cyc(95);
    expect_now("t5_pre_alert", 1'b0, 6'h00, 1'b1, 8'd99, 1'b1);
    cyc(1);
    expect_now("t5_alert", 1'b0, 6'h3F, 1'b1, 8'd100, 1'b1);
    cyc(1);
    expect_now("t5_req_again", 1'b1, 6'h3F, 1'b1, 8'd100, 1'b1);

    // Reset in the middle of a tripped, armed run.
    step = 6'h3F;
    cyc(61);
    expect_now("t6_mid_run", 1'b1, 6'h00, 1'b1, 8'd59, 1'b1);
    rst_n = 1'b0; step = '0; arm_endstop = 1'b1;
    cyc(1);
    expect_now("t6_reset", 1'b0, 6'h00, 1'b0, 8'd0, 1'b1);
    rst_n = 1'b1;
    cyc(100);
    expect_now("t6_pre_alert", 1'b0, 6'h00, 1'b0, 8'd99, 1'b1);
    cyc(1);
    expect_now("t6_alert", 1'b0, 6'h3F, 1'b0, 8'd100, 1'b1);
    cyc(2);
    expect_now("t6_unarmed_no_req", 1'b0, 6'h3F, 1'b0, 8'd100, 1'b1);

    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_leftover: %0d expectations unconsumed, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
